// File: rtl/ptf_rmw_sequencer.sv
// Packs projective-transform pixels into two-pixel memory words and commits them
// to the PTF memory port, using read-modify-write when only one half is known.
module ptf_rmw_sequencer #(
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned MEM_W    = 36,
    parameter int unsigned PIX_W    = 18,
    parameter int unsigned TRUNC_W  = 12,
    parameter int unsigned READ_LAT = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pt_flag,
    input  logic [X_W-1:0]     pt_x,
    input  logic [Y_W-1:0]     pt_y,
    input  logic [TRUNC_W-1:0] pt_pixel,
    output logic               done_pt,
    input  logic               flush,
    output logic               busy,
    output logic               ptf_flag,
    output logic               ptf_wr,
    output logic [X_W-1:0]     ptf_x,
    output logic [Y_W-1:0]     ptf_y,
    output logic [MEM_W-1:0]   ptf_pixel_write,
    input  logic               done_ptf,
    input  logic [MEM_W-1:0]   ptf_pixel_read
);

    localparam int unsigned WX_W  = X_W - 1;
    localparam int unsigned CNT_W = $clog2(READ_LAT + 1);
    localparam int unsigned PAD_W = PIX_W - TRUNC_W;

    typedef enum logic [1:0] {COLLECT, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t            state, state_nx;
    logic [WX_W-1:0]   word_x, word_x_nx;
    logic [Y_W-1:0]    word_y, word_y_nx;
    logic [MEM_W-1:0]  data, data_nx;
    logic [1:0]        valid, valid_nx;
    logic              flush_pend, flush_pend_nx, flush_clr;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic              same_word;
    logic              accept;
    logic [PIX_W-1:0]  pix_exp;

    assign same_word = (pt_x[X_W-1:1] == word_x) && (pt_y == word_y);
    assign accept    = (state == COLLECT) && pt_flag && !flush_pend
                       && ((valid == 2'b00) || same_word);
    assign pix_exp   = PIX_W'(pt_pixel) << PAD_W;

    // Accept is suppressed while reset is held so no handshake leaks out.
    assign done_pt = accept && !reset;
    assign busy    = (valid != 2'b00) || flush_pend || (state != COLLECT);

    // Next-state and buffer update; valid[1] tracks the upper (even-x) half.
    always_comb begin
        state_nx  = state;
        word_x_nx = word_x;
        word_y_nx = word_y;
        data_nx   = data;
        valid_nx  = valid;
        cnt_nx    = cnt;
        flush_clr = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    word_x_nx = pt_x[X_W-1:1];
                    word_y_nx = pt_y;
                    if (pt_x[0]) begin
                        data_nx[PIX_W-1:0] = pix_exp;
                        valid_nx[0]        = 1'b1;
                    end else begin
                        data_nx[MEM_W-1:PIX_W] = pix_exp;
                        valid_nx[1]            = 1'b1;
                    end
                end else if ((valid != 2'b00) && (flush_pend || pt_flag)) begin
                    state_nx = (valid == 2'b11) ? WR_REQ : RD_REQ;
                end else if (flush_pend) begin
                    flush_clr = 1'b1;
                end
            end
            RD_REQ: begin
                if (done_ptf) begin
                    state_nx = RD_WAIT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (cnt == CNT_W'(READ_LAT)) begin
                    if (!valid[1]) data_nx[MEM_W-1:PIX_W] = ptf_pixel_read[MEM_W-1:PIX_W];
                    if (!valid[0]) data_nx[PIX_W-1:0]     = ptf_pixel_read[PIX_W-1:0];
                    valid_nx = 2'b11;
                    cnt_nx   = '0;
                    state_nx = WR_REQ;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WR_REQ: begin
                if (done_ptf) begin
                    valid_nx = 2'b00;
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
        flush_pend_nx = flush || (flush_pend && !flush_clr);
    end

    // State, buffer and registered memory-port outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= COLLECT;
            word_x          <= '0;
            word_y          <= '0;
            data            <= '0;
            valid           <= 2'b00;
            flush_pend      <= 1'b0;
            cnt             <= '0;
            ptf_flag        <= 1'b0;
            ptf_wr          <= 1'b0;
            ptf_x           <= '0;
            ptf_y           <= '0;
            ptf_pixel_write <= '0;
        end else begin
            state           <= state_nx;
            word_x          <= word_x_nx;
            word_y          <= word_y_nx;
            data            <= data_nx;
            valid           <= valid_nx;
            flush_pend      <= flush_pend_nx;
            cnt             <= cnt_nx;
            ptf_flag        <= (state_nx == RD_REQ) || (state_nx == WR_REQ);
            ptf_wr          <= (state_nx == WR_REQ);
            ptf_x           <= {word_x_nx, 1'b0};
            ptf_y           <= word_y_nx;
            ptf_pixel_write <= data_nx;
        end
    end

endmodule

// File: tb/tb_ptf_rmw_sequencer.sv
// Directed bench for ptf_rmw_sequencer with a small memory model on the PTF port.
module tb_ptf_rmw_sequencer;

    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned MEM_W    = 36;
    localparam int unsigned PIX_W    = 18;
    localparam int unsigned TRUNC_W  = 12;
    localparam int unsigned READ_LAT = 2;
    localparam logic [MEM_W-1:0] JUNK = 36'hABCDEABCD;

    logic               clock = 1'b0;
    logic               reset;
    logic               pt_flag;
    logic [X_W-1:0]     pt_x;
    logic [Y_W-1:0]     pt_y;
    logic [TRUNC_W-1:0] pt_pixel;
    logic               done_pt;
    logic               flush;
    logic               busy;
    logic               ptf_flag;
    logic               ptf_wr;
    logic [X_W-1:0]     ptf_x;
    logic [Y_W-1:0]     ptf_y;
    logic [MEM_W-1:0]   ptf_pixel_write;
    logic               done_ptf;
    logic [MEM_W-1:0]   ptf_pixel_read = '0;

    logic [MEM_W-1:0]   mem_ret;
    int checks   = 0;
    int failures = 0;
    int cyc = 0, rd_left = 0;
    int rd_count = 0, wr_count = 0, rd_cyc = 0, wr_cyc = 0;
    logic [X_W-1:0]     rd_x = '0, wr_x = '0;
    logic [Y_W-1:0]     rd_y = '0, wr_y = '0;
    logic [MEM_W-1:0]   wr_data = '0;
    int rd0, wr0;

    ptf_rmw_sequencer #(
        .X_W(X_W), .Y_W(Y_W), .MEM_W(MEM_W), .PIX_W(PIX_W),
        .TRUNC_W(TRUNC_W), .READ_LAT(READ_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .pt_flag(pt_flag), .pt_x(pt_x), .pt_y(pt_y), .pt_pixel(pt_pixel),
        .done_pt(done_pt), .flush(flush), .busy(busy),
        .ptf_flag(ptf_flag), .ptf_wr(ptf_wr), .ptf_x(ptf_x), .ptf_y(ptf_y),
        .ptf_pixel_write(ptf_pixel_write), .done_ptf(done_ptf),
        .ptf_pixel_read(ptf_pixel_read)
    );

    always #5 clock = ~clock;

    // Memory model: logs grants and returns read data READ_LAT cycles after a read grant.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rd_left != 0) begin
            rd_left <= rd_left - 1;
            if (rd_left == 1) ptf_pixel_read <= mem_ret;
        end
        if (ptf_flag && done_ptf) begin
            if (ptf_wr) begin
                wr_count <= wr_count + 1;
                wr_x     <= ptf_x;
                wr_y     <= ptf_y;
                wr_data  <= ptf_pixel_write;
                wr_cyc   <= cyc;
            end else begin
                rd_count       <= rd_count + 1;
                rd_x           <= ptf_x;
                rd_y           <= ptf_y;
                rd_cyc         <= cyc;
                rd_left        <= READ_LAT - 1;
                ptf_pixel_read <= (READ_LAT == 1) ? mem_ret : JUNK;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [TRUNC_W-1:0] v);
        pt_flag  = 1'b1;
        pt_x     = X_W'(x);
        pt_y     = Y_W'(y);
        pt_pixel = v;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        #1 chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; pt_flag = 1'b0; pt_x = '0; pt_y = '0; pt_pixel = '0;
        flush = 1'b0; done_ptf = 1'b0; mem_ret = '0;

        // Reset values, with a pixel presented to prove done_pt is held low
        repeat (2) @(negedge clock);
        pix(4, 3, 12'h111);
        #1;
        chk("rst_done_pt", 64'(done_pt), 64'd0);
        chk("rst_ptf_flag", 64'(ptf_flag), 64'd0);
        chk("rst_ptf_wr", 64'(ptf_wr), 64'd0);
        chk("rst_ptf_x", 64'(ptf_x), 64'd0);
        chk("rst_ptf_y", 64'(ptf_y), 64'd0);
        chk("rst_wdata", 64'(ptf_pixel_write), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        pt_flag = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        done_ptf = 1'b1;

        // Complete pair written directly, no read
        rd0 = rd_count; wr0 = wr_count;
        @(negedge clock); pix(4, 3, 12'hABC); #1 chk("pair_acc_a", 64'(done_pt), 64'd1);
        @(negedge clock); pix(5, 3, 12'h123); #1 chk("pair_acc_b", 64'(done_pt), 64'd1);
        @(negedge clock); pix(8, 3, 12'h456); #1 chk("pair_conflict", 64'(done_pt), 64'd0);
        @(negedge clock); #1;
        chk("pair_flag", 64'(ptf_flag), 64'd1);
        chk("pair_wr", 64'(ptf_wr), 64'd1);
        chk("pair_x", 64'(ptf_x), 64'd4);
        chk("pair_y", 64'(ptf_y), 64'd3);
        chk("pair_data", 64'(ptf_pixel_write), 64'({18'h2AF00, 18'h048C0}));
        chk("pair_no_acc", 64'(done_pt), 64'd0);
        @(negedge clock); #1 chk("pair_acc_c", 64'(done_pt), 64'd1);
        @(negedge clock);
        pt_flag = 1'b0;
        #1;
        chk("pair_wcount", 64'(wr_count - wr0), 64'd1);
        chk("pair_rcount", 64'(rd_count - rd0), 64'd0);
        chk("pair_wdata", 64'(wr_data), 64'({18'h2AF00, 18'h048C0}));

        // Flush the lone C at (8,3) against zero memory
        mem_ret = '0;
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        wait_idle("c_idle");
        chk("c_wdata", 64'(wr_data), 64'({18'h11580, 18'h00000}));
        chk("c_wx", 64'(wr_x), 64'd8);

        // Lone pixel RMW; flush arrives in the same cycle as the accept
        rd0 = rd_count; wr0 = wr_count;
        mem_ret = 36'h123456789;
        @(negedge clock); pix(7, 2, 12'h3C5); flush = 1'b1;
        #1 chk("rmw_acc", 64'(done_pt), 64'd1);
        @(negedge clock); pt_flag = 1'b0; flush = 1'b0;
        wait_idle("rmw_idle");
        chk("rmw_rcount", 64'(rd_count - rd0), 64'd1);
        chk("rmw_rx", 64'(rd_x), 64'd6);
        chk("rmw_ry", 64'(rd_y), 64'd2);
        chk("rmw_wcount", 64'(wr_count - wr0), 64'd1);
        chk("rmw_wx", 64'(wr_x), 64'd6);
        chk("rmw_wy", 64'(wr_y), 64'd2);
        chk("rmw_wdata", 64'(wr_data), 64'({18'h048D1, 18'h0F140}));
        chk("rmw_latency", 64'(wr_cyc - rd_cyc), 64'd3);

        // Overwrite of the same half before commit
        rd0 = rd_count; wr0 = wr_count;
        mem_ret = 36'hFEDCBA987;
        @(negedge clock); pix(4, 3, 12'hABC); #1 chk("ovw_acc_a", 64'(done_pt), 64'd1);
        @(negedge clock); pix(4, 3, 12'h5A5); #1 chk("ovw_acc_d", 64'(done_pt), 64'd1);
        @(negedge clock); pt_flag = 1'b0; flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        wait_idle("ovw_idle");
        chk("ovw_rcount", 64'(rd_count - rd0), 64'd1);
        chk("ovw_wcount", 64'(wr_count - wr0), 64'd1);
        chk("ovw_wdata", 64'(wr_data), 64'({18'h16940, 18'h3A987}));

        // Write stalled for five cycles with a conflicting pixel held
        wr0 = wr_count;
        done_ptf = 1'b0;
        @(negedge clock); pix(10, 5, 12'h001);
        @(negedge clock); pix(11, 5, 12'hFFF);
        @(negedge clock); pix(12, 5, 12'h800);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            chk("stall_flag", 64'(ptf_flag), 64'd1);
            chk("stall_wr", 64'(ptf_wr), 64'd1);
            chk("stall_x", 64'(ptf_x), 64'd10);
            chk("stall_y", 64'(ptf_y), 64'd5);
            chk("stall_data", 64'(ptf_pixel_write), 64'({18'h00040, 18'h3FFC0}));
            chk("stall_no_acc", 64'(done_pt), 64'd0);
        end
        done_ptf = 1'b1;
        @(negedge clock); #1 chk("stall_acc_g", 64'(done_pt), 64'd1);
        chk("stall_wcount", 64'(wr_count - wr0), 64'd1);
        @(negedge clock); pt_flag = 1'b0; flush = 1'b1; mem_ret = '0;
        @(negedge clock); flush = 1'b0;
        wait_idle("g_idle");
        chk("g_wdata", 64'(wr_data), 64'({18'h20000, 18'h00000}));

        // Reset while waiting on read data
        rd0 = rd_count; wr0 = wr_count;
        mem_ret = 36'h0000FFFFF;
        @(negedge clock); pix(3, 1, 12'h777);
        @(negedge clock); pt_flag = 1'b0; flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        begin
            int n = 0;
            while (!(ptf_flag === 1'b1 && ptf_wr === 1'b0) && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        chk("rw_read_seen", 64'(ptf_flag && !ptf_wr), 64'd1);
        @(negedge clock); #1 chk("rw_busy_pre", 64'(busy), 64'd1);
        chk("rw_x_pre", 64'(ptf_x), 64'd2);
        reset = 1'b1;
        #1;
        chk("rw_flag", 64'(ptf_flag), 64'd0);
        chk("rw_wr", 64'(ptf_wr), 64'd0);
        chk("rw_x", 64'(ptf_x), 64'd0);
        chk("rw_y", 64'(ptf_y), 64'd0);
        chk("rw_wdata", 64'(ptf_pixel_write), 64'd0);
        chk("rw_busy", 64'(busy), 64'd0);
        @(negedge clock); reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        chk("rw_no_write", 64'(wr_count - wr0), 64'd0);
        chk("rw_rcount", 64'(rd_count - rd0), 64'd1);
        chk("rw_flag_after", 64'(ptf_flag), 64'd0);
        chk("rw_busy_after", 64'(busy), 64'd0);

        // Flush with an empty buffer
        rd0 = rd_count; wr0 = wr_count;
        @(negedge clock); flush = 1'b1;
        #1 chk("fe_busy0", 64'(busy), 64'd0);
        @(negedge clock); flush = 1'b0;
        #1 chk("fe_busy1", 64'(busy), 64'd1);
        chk("fe_flag1", 64'(ptf_flag), 64'd0);
        @(negedge clock); #1 chk("fe_busy2", 64'(busy), 64'd0);
        chk("fe_flag2", 64'(ptf_flag), 64'd0);
        repeat (2) @(negedge clock);
        chk("fe_no_mem", 64'((rd_count - rd0) + (wr_count - wr0)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
